// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Iterative unsigned restoring divider. A 2N-bit dividend is divided by an
//   N-bit divisor, producing a 2N-bit quotient and N-bit remainder, one
//   quotient bit per clock behind a start/done handshake.
//
//   Ports
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   request, sampled only while idle
//     P      in   2N-bit dividend, captured on the accepted start edge
//     B      in   N-bit divisor, captured on the accepted start edge
//     busy   out  high whenever the block is not idle
//     done   out  one-cycle completion pulse
//     Q      out  2N-bit quotient (registered, holds until next completion)
//     R      out  N-bit remainder (registered, holds until next completion)
//     dz     out  divide-by-zero flag (registered)
//
//   Build option
//     DIV_ZERO_CHK_EN : when defined, B=0 bypasses the iteration and
//                       completes one cycle after start with dz=1. When
//                       undefined, dz is always 0 and B=0 iterates normally
//                       (giving Q=all ones, R=P[N-1:0]).
module seq_restoring_divider #(
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] P,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Q,
  output logic [N-1:0]   R,
  output logic           dz
);
  localparam int            CW   = (2*N > 1) ? $clog2(2*N) : 1;
  localparam logic [CW-1:0] LAST = CW'(2*N-1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e state_q, state_d;

  logic [2*N-1:0] dvd_q, dvd_d;   // dividend shift register
  logic [2*N-1:0] quo_q, quo_d;   // working quotient
  logic [N-1:0]   div_q, div_d;   // captured divisor
  logic [N-1:0]   rem_q, rem_d;   // partial remainder
  logic [CW-1:0]  cnt_q, cnt_d;   // step counter
  logic [2*N-1:0] q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic           dz_q, dz_d;

  logic [N:0]     t;
  logic [N-1:0]   diff;
  logic           ge;
  logic           zero_fast;

`ifdef DIV_ZERO_CHK_EN
  assign zero_fast = (B == '0);
`else
  assign zero_fast = 1'b0;
`endif

  // Trial subtraction. Only the low N bits of t-B are ever kept (the result
  // is < B when ge), so the subtract is done at N bits.
  assign t    = {rem_q, dvd_q[2*N-1]};
  assign ge   = (t >= {1'b0, div_q});
  assign diff = t[N-1:0] - div_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = zero_fast ? DONE : RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign Q  = q_q;
  assign R  = r_q;
  assign dz = dz_q;

  // Datapath next-state
  always_comb begin
    dvd_d = dvd_q;
    quo_d = quo_q;
    div_d = div_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    r_d   = r_q;
    dz_d  = dz_q;
    case (state_q)
      IDLE: if (start) begin
        dvd_d = P;
        div_d = B;
        rem_d = '0;
        quo_d = '0;
        cnt_d = '0;
        // Fast path publishes the same result the iteration would produce.
        if (zero_fast) begin
          q_d  = '1;
          r_d  = P[N-1:0];
          dz_d = 1'b1;
        end
      end
      RUN: begin
        rem_d = ge ? diff : t[N-1:0];
        dvd_d = dvd_q << 1;
        quo_d = {quo_q[2*N-2:0], ge};
        cnt_d = cnt_q + 1'b1;
        // Final step: publish the freshly computed working values.
        if (cnt_q == LAST) begin
          q_d  = quo_d;
          r_d  = rem_d;
          dz_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dz_q  <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      quo_q <= quo_d;
      div_q <= div_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dz_q  <= dz_d;
    end
  end

endmodule
